sli_frame_sequencer: RTL and testbench
======================================

Name: sli_frame_sequencer

Overview:
- Central scheduler for the structured-light pixel pipeline.
- Decides once per frame, at the vsync rising edge, whether the pipe advances to the next pattern index (frq, fra) or holds the current one.
- Advancement is paced by camera-ready GPIO pulses, tracked as credits.
- Also generates the camera trigger, the display-mode latch and sequence status flags. The LUT/index-map datapath consumes its outputs.

Parameters:
NUM_FRQ, 4, number of spatial-frequency groups (1..4); frq wraps at NUM_FRQ-1.
FRAMES_PER_FRQ, 8, frames per frequency group (1..8); fra wraps at FRAMES_PER_FRQ-1.
CREDIT_W, 4, width of the ready-credit counter; saturates at 2^CREDIT_W-1.
TIMEOUT_FRAMES, 64, consecutive held frames in RUN before timeout is flagged (1..255).

Ports:
clk  in  1  pixel clock; the only clock.
rst_n  in  1  synchronous active-low reset.
mode  in  1  1 = structured-light sequencing, 0 = pass-through; synchronous to clk.
ori  in  1  stripe orientation select; synchronous to clk.
in_vsync  in  1  vsync from timing source; synchronous to clk.
rdy  in  1  camera-ready GPIO; asynchronous.
frq  out  2  spatial-frequency index.
fra  out  3  frame index within the group.
hold  out  1  1 = current frame repeats the previous pattern.
trig  out  1  camera trigger.
f_frm  out  1  high when frq==0 and fra==0.
disp_mode  out  1  mode latched at the vsync falling edge; selects pattern vs pass-through.
seq_done  out  1  one-cycle pulse when the index wraps from (NUM_FRQ-1, FRAMES_PER_FRQ-1) to (0,0).
credit  out  CREDIT_W  current ready-credit count.
ovf  out  1  sticky: a ready pulse arrived while credit was saturated.
timeout  out  1  sticky: TIMEOUT_FRAMES consecutive held frames in RUN.

Behaviour:
- Reset when rst_n=0 at a clk edge. All outputs 0 except hold=1. State = IDLE. Synchronisers and edge registers are cleared.
- Input conditioning:
  - rdy passes through a 2-flop synchroniser plus one edge register.
  - rdy_rise = s2 & ~s3, which is 3 cycles after the external edge.
  - vs_rise = in_vsync & ~vsync_q.
  - vs_fall = ~in_vsync & vsync_q.
  - mode_rise and mode_fall are detected from mode_q.
- All state and output updates happen on the clk edge where the event is true; they are visible the next cycle.
- disp_mode <= mode on every vs_fall, in all states.
- FSM states: IDLE, ARM, RUN.
- IDLE:
  - Outputs: frq=0, fra=0, hold=1, credit=0, trig=0.
  - mode_rise -> ARM.
- ARM:
  - Waits for vs_rise.
  - On vs_rise: index=(0,0), hold=0, credit=0, capture ori into ori_q, timeout counter cleared -> RUN.
  - mode_fall -> IDLE.
- RUN, on vs_rise, with priority in this order:
  1. ori != ori_q: set index=(0,0), hold=1, credit=0, ori_q<=ori.
  2. Else if credit!=0 or rdy_rise is true this cycle:
     - fra advances; on wrap fra=0 and frq advances.
     - frq wraps at NUM_FRQ-1; seq_done pulses on the full wrap.
     - hold=0. Held-frame counter cleared.
     - New credit = credit - 1 + rdy_rise, so a simultaneous pulse leaves credit unchanged.
  3. Else: hold=1, held-frame counter+1. timeout is set when the counter reaches TIMEOUT_FRAMES.
- RUN, rdy_rise without vs_rise: credit+1, saturating. At saturation, ovf is set.
- mode_fall in any state: -> IDLE the same edge. It overrides a coincident vs_rise or rdy_rise. Credit is cleared; ovf and timeout are cleared.
- mode_rise while in ARM or RUN: restart into ARM. Credit is cleared.
- trig:
  - Set on the edge after a vs_rise that produced hold=0, whether from ARM entry or advancement.
  - Cleared on vs_fall.
  - 0 whenever the state is IDLE or the frame is held.
- f_frm is combinational from the registered frq and fra.
- Width rules:
  - frq and fra compare against parameter-1 before incrementing; no reliance on natural overflow.
  - Credit arithmetic is unsigned and never underflows.

Test Plan:
- Reset sequence: rst_n low 4 cycles with mode=1, vsync toggling -> hold=1, frq=fra=0, trig=0, credit=0 throughout, and 1 cycle after release.
- mode 0->1, then vsync rising -> state RUN, hold=0, trig high until vsync falls. Next vsync with no rdy pulse -> hold=1, trig stays 0, index stays (0,0).
- 3 rdy pulses within one frame, then 4 vsyncs -> credit goes 3,2,1,0; fra goes 1,2,3; the fourth vsync holds with hold=1.
- rdy_rise on the same cycle as vs_rise with credit=0 -> fra advances, credit remains 0. With defaults, 31 advances from (0,0) -> (3,7); the next advance gives a seq_done pulse and (0,0).
- ori toggled mid-sequence at (1,5) -> next vsync gives (0,0), hold=1, credit=0. 16 rdy pulses with CREDIT_W=4 -> credit=15, ovf=1.
- TIMEOUT_FRAMES=4 with no rdy -> timeout set on the 4th held vsync. A mode fall on the same cycle as vs_rise -> IDLE, index (0,0), timeout and ovf cleared.

Source files
------------

// File: rtl/sli_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its environment: timing and
// camera-ready inputs plus the pattern index, trigger and status outputs.
interface sli_frame_sequencer_if #(
    parameter int CREDIT_W = 4
);
    logic                mode;
    logic                ori;
    logic                in_vsync;
    logic                rdy;
    logic [1:0]          frq;
    logic [2:0]          fra;
    logic                hold;
    logic                trig;
    logic                f_frm;
    logic                disp_mode;
    logic                seq_done;
    logic [CREDIT_W-1:0] credit;
    logic                ovf;
    logic                timeout;

    modport master (
        output mode, ori, in_vsync, rdy,
        input  frq, fra, hold, trig, f_frm, disp_mode, seq_done, credit, ovf, timeout
    );

    modport slave (
        input  mode, ori, in_vsync, rdy,
        output frq, fra, hold, trig, f_frm, disp_mode, seq_done, credit, ovf, timeout
    );
endinterface

// File: rtl/sli_frame_sequencer.sv
// Structured-light frame sequencer: once per frame (vsync rise) decides
// whether the pattern index advances or holds, paced by camera-ready credits.
// Also produces the camera trigger, display-mode latch and status flags.
module sli_frame_sequencer #(
    parameter int NUM_FRQ        = 4,
    parameter int FRAMES_PER_FRQ = 8,
    parameter int CREDIT_W       = 4,
    parameter int TIMEOUT_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sli_frame_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0]          FRQ_LAST   = 2'(NUM_FRQ - 1);
    localparam logic [2:0]          FRA_LAST   = 3'(FRAMES_PER_FRQ - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [7:0]          HELD_LIMIT = 8'(TIMEOUT_FRAMES);

    // Input conditioning: rdy_p0/rdy_p1 form the synchroniser, rdy_p2 is the edge register
    logic rdy_p0, rdy_p1, rdy_p2;
    logic vsync_q, mode_q;
    logic rdy_rise, vs_rise, vs_fall, mode_rise, mode_fall;

    state_t              state_q, state_d;
    logic [1:0]          frq_q, frq_d;
    logic [2:0]          fra_q, fra_d;
    logic                hold_q, hold_d;
    logic                trig_q, trig_d;
    logic                disp_q, disp_d;
    logic                seq_done_q, seq_done_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;
    logic [7:0]          held_q, held_d;
    logic                ori_q, ori_d;
    logic [7:0]          held_inc;

    // Synchronise rdy and register the level-sensitive inputs for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_p0  <= 1'b0;
            rdy_p1  <= 1'b0;
            rdy_p2  <= 1'b0;
            vsync_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            rdy_p0  <= bus.rdy;
            rdy_p1  <= rdy_p0;
            rdy_p2  <= rdy_p1;
            vsync_q <= bus.in_vsync;
            mode_q  <= bus.mode;
        end
    end

    assign rdy_rise  = rdy_p1 & ~rdy_p2;
    assign vs_rise   = bus.in_vsync & ~vsync_q;
    assign vs_fall   = ~bus.in_vsync & vsync_q;
    assign mode_rise = bus.mode & ~mode_q;
    assign mode_fall = ~bus.mode & mode_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            frq_q      <= 2'd0;
            fra_q      <= 3'd0;
            hold_q     <= 1'b1;
            trig_q     <= 1'b0;
            disp_q     <= 1'b0;
            seq_done_q <= 1'b0;
            credit_q   <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            held_q     <= 8'd0;
            ori_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frq_q      <= frq_d;
            fra_q      <= fra_d;
            hold_q     <= hold_d;
            trig_q     <= trig_d;
            disp_q     <= disp_d;
            seq_done_q <= seq_done_d;
            credit_q   <= credit_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            held_q     <= held_d;
            ori_q      <= ori_d;
        end
    end

    // Next-state and output decisions; mode_fall outranks every other event
    always_comb begin
        state_d    = state_q;
        frq_d      = frq_q;
        fra_d      = fra_q;
        hold_d     = hold_q;
        trig_d     = trig_q;
        disp_d     = disp_q;
        seq_done_d = 1'b0;
        credit_d   = credit_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        held_d     = held_q;
        ori_d      = ori_q;
        held_inc   = (held_q == 8'hFF) ? held_q : held_q + 8'd1;

        if (vs_fall) begin
            disp_d = bus.mode;
            trig_d = 1'b0;
        end

        if (mode_fall) begin
            state_d  = S_IDLE;
            frq_d    = 2'd0;
            fra_d    = 3'd0;
            hold_d   = 1'b1;
            trig_d   = 1'b0;
            credit_d = '0;
            ovf_d    = 1'b0;
            tmo_d    = 1'b0;
        end else if (mode_rise) begin
            state_d  = S_ARM;
            credit_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ARM: begin
                    if (vs_rise) begin
                        state_d  = S_RUN;
                        frq_d    = 2'd0;
                        fra_d    = 3'd0;
                        hold_d   = 1'b0;
                        trig_d   = 1'b1;
                        credit_d = '0;
                        ori_d    = bus.ori;
                        held_d   = 8'd0;
                    end
                end
                S_RUN: begin
                    if (vs_rise) begin
                        if (bus.ori != ori_q) begin
                            // Orientation change restarts the sequence on a held frame
                            frq_d    = 2'd0;
                            fra_d    = 3'd0;
                            hold_d   = 1'b1;
                            trig_d   = 1'b0;
                            credit_d = '0;
                            ori_d    = bus.ori;
                        end else if ((credit_q != '0) || rdy_rise) begin
                            if (fra_q == FRA_LAST) begin
                                fra_d = 3'd0;
                                if (frq_q == FRQ_LAST) begin
                                    frq_d      = 2'd0;
                                    seq_done_d = 1'b1;
                                end else begin
                                    frq_d = frq_q + 2'd1;
                                end
                            end else begin
                                fra_d = fra_q + 3'd1;
                            end
                            hold_d   = 1'b0;
                            trig_d   = 1'b1;
                            held_d   = 8'd0;
                            // A coincident ready pulse replaces the credit being spent
                            credit_d = rdy_rise ? credit_q : credit_q - CREDIT_W'(1);
                        end else begin
                            hold_d = 1'b1;
                            trig_d = 1'b0;
                            held_d = held_inc;
                            if (held_inc >= HELD_LIMIT) begin
                                tmo_d = 1'b1;
                            end
                        end
                    end else if (rdy_rise) begin
                        if (credit_q == CREDIT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            credit_d = credit_q + CREDIT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.frq       = frq_q;
    assign bus.fra       = fra_q;
    assign bus.hold      = hold_q;
    assign bus.trig      = trig_q;
    assign bus.f_frm     = (frq_q == 2'd0) && (fra_q == 3'd0);
    assign bus.disp_mode = disp_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.credit    = credit_q;
    assign bus.ovf       = ovf_q;
    assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_sli_frame_sequencer.sv
// Bench for sli_frame_sequencer: directed scenarios followed by randomized
// frames, checked every cycle against a behavioural model of the sequencer.
module tb_sli_frame_sequencer;
    localparam int NF    = 4;
    localparam int FP    = 8;
    localparam int CW    = 4;
    localparam int TO    = 4;
    localparam int TOTAL = NF * FP;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sli_frame_sequencer_if #(.CREDIT_W(CW)) bus();

    sli_frame_sequencer #(
        .NUM_FRQ(NF), .FRAMES_PER_FRQ(FP), .CREDIT_W(CW), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: phase 0 idle, 1 armed, 2 running; index as one linear position
    int m_phase, m_pos, m_credit, m_held;
    bit m_hold, m_trig, m_ovf, m_tmo, m_seq, m_disp, m_oriq, m_valid;
    bit rh0, rh1, rh2, vs_prev, mode_prev;
    bit rr, vr, vf, mr, mf;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1; m_phase = 0; m_pos = 0; m_credit = 0; m_held = 0;
            m_hold = 1'b1; m_trig = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_seq = 1'b0;
            m_disp = 1'b0; m_oriq = 1'b0;
            rh0 = 1'b0; rh1 = 1'b0; rh2 = 1'b0; vs_prev = 1'b0; mode_prev = 1'b0;
        end else begin
            // ready rise is seen three samples after the pin goes high
            rr = rh1 & ~rh2;
            vr = bus.in_vsync & ~vs_prev;
            vf = ~bus.in_vsync & vs_prev;
            mr = bus.mode & ~mode_prev;
            mf = ~bus.mode & mode_prev;
            rh2 = rh1; rh1 = rh0; rh0 = bus.rdy;
            vs_prev = bus.in_vsync; mode_prev = bus.mode;
            m_seq = 1'b0;
            if (vf) begin
                m_disp = bus.mode;
                m_trig = 1'b0;
            end
            if (mf) begin
                m_phase = 0; m_pos = 0; m_hold = 1'b1; m_trig = 1'b0;
                m_credit = 0; m_ovf = 1'b0; m_tmo = 1'b0;
            end else if (mr) begin
                m_phase = 1; m_credit = 0;
            end else if (m_phase == 1) begin
                if (vr) begin
                    m_phase = 2; m_pos = 0; m_hold = 1'b0; m_trig = 1'b1;
                    m_credit = 0; m_oriq = bus.ori; m_held = 0;
                end
            end else if (m_phase == 2) begin
                if (vr) begin
                    if (bus.ori != m_oriq) begin
                        m_pos = 0; m_hold = 1'b1; m_trig = 1'b0; m_credit = 0; m_oriq = bus.ori;
                    end else if (m_credit > 0 || rr) begin
                        if (m_pos == TOTAL - 1) m_seq = 1'b1;
                        m_pos = (m_pos + 1) % TOTAL;
                        m_hold = 1'b0; m_trig = 1'b1; m_held = 0;
                        m_credit = m_credit + int'(rr) - 1;
                    end else begin
                        m_hold = 1'b1; m_trig = 1'b0;
                        if (m_held < 255) m_held = m_held + 1;
                        if (m_held >= TO) m_tmo = 1'b1;
                    end
                end else if (rr) begin
                    if (m_credit == CMAX) m_ovf = 1'b1;
                    else m_credit = m_credit + 1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            checks++;
            if (bus.frq !== 2'(m_pos / FP) || bus.fra !== 3'(m_pos % FP) ||
                bus.hold !== m_hold || bus.trig !== m_trig || bus.f_frm !== (m_pos == 0) ||
                bus.disp_mode !== m_disp || bus.seq_done !== m_seq ||
                bus.credit !== CW'(m_credit) || bus.ovf !== m_ovf || bus.timeout !== m_tmo) begin
                errors++;
                $display("FAIL outputs cyc=%0d got frq=%0d fra=%0d hold=%b trig=%b f_frm=%b disp=%b seq=%b credit=%0d ovf=%b tmo=%b exp frq=%0d fra=%0d hold=%b trig=%b f_frm=%b disp=%b seq=%b credit=%0d ovf=%b tmo=%b",
                         cyc, bus.frq, bus.fra, bus.hold, bus.trig, bus.f_frm, bus.disp_mode,
                         bus.seq_done, bus.credit, bus.ovf, bus.timeout,
                         m_pos / FP, m_pos % FP, m_hold, m_trig, m_pos == 0, m_disp, m_seq,
                         m_credit, m_ovf, m_tmo);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int hi, input int lo);
        bus.in_vsync = 1'b1;
        tick(hi);
        bus.in_vsync = 1'b0;
        tick(lo);
    endtask

    task automatic rdy_pulse();
        bus.rdy = 1'b1;
        tick(2);
        bus.rdy = 1'b0;
        tick(2);
    endtask

    // Ready rise lands on the same edge as the vsync rise
    task automatic adv_coincident(output logic sd);
        bus.rdy = 1'b1;
        tick(2);
        bus.in_vsync = 1'b1;
        bus.rdy = 1'b0;
        tick(1);
        sd = bus.seq_done;
        tick(2);
        bus.in_vsync = 1'b0;
        tick(4);
    endtask

    initial begin
        logic sd;
        int hi, lo;
        bus.mode = 1'b1; bus.ori = 1'b0; bus.in_vsync = 1'b0; bus.rdy = 1'b0;
        rst_n = 1'b0;

        // Reset with mode high and vsync toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("rst_hold", bus.hold, 1);
            lit("rst_idx", {bus.frq, bus.fra}, 0);
            lit("rst_trig_credit", {bus.trig, bus.credit}, 0);
            bus.in_vsync = ~bus.in_vsync;
        end
        rst_n = 1'b1;
        bus.in_vsync = 1'b0;
        tick(1);
        lit("post_rst_hold", bus.hold, 1);
        lit("post_rst_trig", bus.trig, 0);
        tick(2);

        // First vsync arms the run: advance with trigger until vsync falls
        bus.in_vsync = 1'b1;
        tick(1);
        lit("run_hold", bus.hold, 0);
        lit("run_trig", bus.trig, 1);
        tick(3);
        bus.in_vsync = 1'b0;
        tick(1);
        lit("trig_clear", bus.trig, 0);
        lit("disp_mode", bus.disp_mode, 1);
        tick(3);
        frame(3, 5);
        lit("held_hold", bus.hold, 1);
        lit("held_idx", {bus.frq, bus.fra}, 0);

        // Three credits consumed by four vsyncs
        repeat (3) rdy_pulse();
        lit("credit3", bus.credit, 3);
        lit("model_credit3", m_credit, 3);
        for (int i = 0; i < 3; i++) begin
            frame(2, 4);
            lit("credit_dec", bus.credit, 2 - i);
            lit("fra_inc", bus.fra, i + 1);
        end
        frame(2, 4);
        lit("fourth_hold", bus.hold, 1);
        lit("fourth_fra", bus.fra, 3);

        // Coincident ready/vsync advances to the end and wraps
        for (int i = 0; i < 28; i++) adv_coincident(sd);
        lit("end_frq", bus.frq, 3);
        lit("end_fra", bus.fra, 7);
        lit("model_end_pos", m_pos, 31);
        lit("end_credit", bus.credit, 0);
        adv_coincident(sd);
        lit("seq_done", sd, 1);
        lit("wrap_idx", {bus.frq, bus.fra}, 0);
        lit("wrap_f_frm", bus.f_frm, 1);

        // Orientation change at (1,5), then credit saturation
        for (int i = 0; i < 13; i++) adv_coincident(sd);
        lit("ori_pre_idx", {bus.frq, bus.fra}, {2'd1, 3'd5});
        bus.ori = 1'b1;
        frame(3, 4);
        lit("ori_idx", {bus.frq, bus.fra}, 0);
        lit("ori_hold", bus.hold, 1);
        lit("ori_credit", bus.credit, 0);
        repeat (15) rdy_pulse();
        lit("sat_credit", bus.credit, 15);
        lit("sat_no_ovf", bus.ovf, 0);
        rdy_pulse();
        lit("ovf_credit", bus.credit, 15);
        lit("ovf", bus.ovf, 1);

        // Spend credits, then hold until timeout
        repeat (15) frame(2, 4);
        lit("spent_idx", {bus.frq, bus.fra}, {2'd1, 3'd7});
        lit("spent_credit", bus.credit, 0);
        repeat (3) frame(2, 4);
        lit("tmo_not_yet", bus.timeout, 0);
        frame(2, 4);
        lit("tmo_set", bus.timeout, 1);
        lit("model_tmo", m_tmo, 1);

        // mode fall coincident with vsync rise
        bus.mode = 1'b0;
        bus.in_vsync = 1'b1;
        tick(1);
        lit("mf_idx", {bus.frq, bus.fra}, 0);
        lit("mf_flags", {bus.timeout, bus.ovf, bus.trig}, 0);
        lit("mf_hold", bus.hold, 1);
        bus.in_vsync = 1'b0;
        tick(2);
        lit("mf_disp", bus.disp_mode, 0);

        // Randomized frames with ready noise, orientation flips and mode drops
        bus.mode = 1'b1;
        tick(3);
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 15) == 0) bus.ori = ~bus.ori;
            bus.mode = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            hi = $urandom_range(1, 4);
            lo = $urandom_range(2, 12);
            bus.in_vsync = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) bus.in_vsync = 1'b0;
                if ($urandom_range(0, 3) == 0) bus.rdy = ~bus.rdy;
                tick(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
